// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked flip-flops with a global SR/JK/D/T mode select.
// Colliding SR set/clear requests are resolved by SR_POLICY and logged in sticky flags and a saturating counter.
module sr_ff_bank #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8,
  parameter int SR_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] err_flags,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0]       MODE_SR = 2'b00;
  localparam logic [1:0]       MODE_JK = 2'b01;
  localparam logic [1:0]       MODE_D  = 2'b10;
  localparam logic [1:0]       MODE_T  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic             any_illegal;

  // Per-bit next state. With en low, q_next stays at q_reg, so every bit holds and nothing is flagged.
  always_comb begin
    q_next  = q_reg;
    illegal = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_SR: begin
            case ({s[i], r[i]})
              2'b10: q_next[i] = 1'b1;
              2'b01: q_next[i] = 1'b0;
              2'b11: begin
                illegal[i] = 1'b1;
                case (SR_POLICY)
                  1:       q_next[i] = 1'b1;
                  2:       q_next[i] = 1'b0;
                  default: q_next[i] = q_reg[i];
                endcase
              end
              default: q_next[i] = q_reg[i];
            endcase
          end
          MODE_JK: begin
            case ({s[i], r[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11:   q_next[i] = ~q_reg[i];
              default: q_next[i] = q_reg[i];
            endcase
          end
          MODE_D:  q_next[i] = s[i];
          MODE_T:  q_next[i] = q_reg[i] ^ s[i];
          default: q_next[i] = q_reg[i];
        endcase
      end
    end
  end

  assign any_illegal = |illegal;

  // A clear on the same edge as a new illegal event keeps only that edge's event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg     <= '0;
      err_flags <= '0;
      err_count <= '0;
    end else begin
      q_reg <= q_next;
      if (clr_err) begin
        err_flags <= illegal;
        err_count <= any_illegal ? CNT_ONE : '0;
      end else begin
        err_flags <= err_flags | illegal;
        if (any_illegal && (err_count != CNT_MAX)) begin
          err_count <= err_count + CNT_ONE;
        end
      end
    end
  end

  assign q   = q_reg;
  assign q_n = ~q_reg;

endmodule
